// File: rtl/route_cmd_control_if.sv
// Command and barcode-ID handshake channels into route_cmd_control.
// Latency: wires only; no storage.
// Backpressure: none; each held valid is released by its consume pulse.
//
// Signals:
//   cmd / cmd_rdy / clr_cmd_rdy : UART command word, held valid, consume pulse
//   ID  / ID_vld  / clr_ID_vld  : barcode station ID, held valid, consume pulse
// Modports: master = upstream producers, slave = route_cmd_control.
interface route_cmd_control_if #(
  parameter int ID_W = 6
) ();
  logic [ID_W+1:0] cmd;
  logic            cmd_rdy;
  logic            clr_cmd_rdy;
  logic [ID_W-1:0] ID;
  logic            ID_vld;
  logic            clr_ID_vld;

  modport master (
    output cmd, cmd_rdy, ID, ID_vld,
    input  clr_cmd_rdy, clr_ID_vld
  );

  modport slave (
    input  cmd, cmd_rdy, ID, ID_vld,
    output clr_cmd_rdy, clr_ID_vld
  );
endinterface

// File: rtl/route_cmd_control.sv
// Queued multi-stop route controller: commands fill a destination FIFO and
// barcode IDs matching the head pop it.
// Latency: state/q_cnt update on the edge sampling a command or a matching ID;
// arrived/ovf are registered one-cycle pulses.
// Backpressure: none; every command is consumed at once, and an ID is deferred
// one cycle when it collides with a command.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : command / ID channels (slave modport)
//   OK2Move     : path clear from proximity sensing
//   in_transit  : route active (registered state bit)
//   go          : motion enable = in_transit & OK2Move
//   buzz/buzz_n : differential piezo drive, active while blocked in transit
//   arrived     : pulse on head match
//   ovf         : pulse when a push is dropped on a full queue
//   q_cnt       : queue occupancy
module route_cmd_control #(
  parameter int ID_W      = 6,
  parameter int DEPTH     = 4,
  parameter int BUZZ_HALF = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  route_cmd_control_if.slave         bus,
  input  logic                       OK2Move,
  output logic                       in_transit,
  output logic                       go,
  output logic                       buzz,
  output logic                       buzz_n,
  output logic                       arrived,
  output logic                       ovf,
  output logic [$clog2(DEPTH+1)-1:0] q_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BC_W  = $clog2(BUZZ_HALF) + 1;

  typedef enum logic {IDLE = 1'b0, TRANSIT = 1'b1} state_t;
  typedef enum logic [1:0] {
    OP_STOP   = 2'b00,
    OP_GO     = 2'b01,
    OP_ENQ    = 2'b10,
    OP_RESUME = 2'b11
  } op_t;

  state_t           state;
  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [BC_W-1:0]  bcnt;
  logic             buzz_act;

  op_t             op;
  logic [ID_W-1:0] dest;
  logic [ID_W-1:0] head;
  logic            full, is_push_op, do_push, ovf_evt, do_pop, buzz_cond;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign op         = op_t'(bus.cmd[ID_W+1:ID_W]);
  assign dest       = bus.cmd[ID_W-1:0];
  assign head       = mem[rd_ptr];
  assign full       = (q_cnt == CNT_W'(DEPTH));
  assign is_push_op = bus.cmd_rdy && (op == OP_GO || op == OP_ENQ);
  assign do_push    = is_push_op && !full;
  assign ovf_evt    = is_push_op && full;
  // A pending command takes the cycle; the ID stays held and is seen next cycle.
  assign do_pop     = !bus.cmd_rdy && bus.ID_vld && (state == TRANSIT) &&
                      (q_cnt != '0) && (bus.ID == head);

  assign bus.clr_cmd_rdy = bus.cmd_rdy;
  assign bus.clr_ID_vld  = bus.ID_vld && !bus.cmd_rdy;

  assign in_transit = (state == TRANSIT);
  assign go         = in_transit && OK2Move;
  assign buzz_cond  = in_transit && !OK2Move;

  // Queue storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_cnt   <= '0;
      arrived <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      arrived <= do_pop;
      ovf     <= ovf_evt;
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        q_cnt  <= q_cnt + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        q_cnt  <= q_cnt - 1'b1;
      end
      if (bus.cmd_rdy) begin
        case (op)
          OP_STOP: begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
            state  <= IDLE;
          end
          OP_GO:     state <= TRANSIT;
          OP_RESUME: if (q_cnt != '0) state <= TRANSIT;
          default: ;
        endcase
      end else if (do_pop && q_cnt == CNT_W'(1)) begin
        state <= IDLE;
      end
    end
  end

  // Buzzer: the first active edge loads buzz=1, then toggles every BUZZ_HALF
  // cycles; losing the condition parks both legs low.
  always_ff @(posedge clk) begin
    if (rst || !buzz_cond) begin
      buzz     <= 1'b0;
      buzz_n   <= 1'b0;
      bcnt     <= '0;
      buzz_act <= 1'b0;
    end else if (!buzz_act) begin
      buzz_act <= 1'b1;
      buzz     <= 1'b1;
      buzz_n   <= 1'b0;
      bcnt     <= '0;
    end else if (bcnt == BC_W'(BUZZ_HALF-1)) begin
      bcnt   <= '0;
      buzz   <= ~buzz;
      buzz_n <= buzz;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_route_cmd_control.sv
module tb_route_cmd_control;

  localparam int ID_W = 6;
  localparam int DEPTH = 4;
  localparam int BUZZ_HALF = 4;

  localparam logic [1:0] STOP = 2'b00, GO = 2'b01, ENQ = 2'b10, RESUME = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       OK2Move = 1'b1;
  logic       in_transit, go, buzz, buzz_n, arrived, ovf;
  logic [2:0] q_cnt;

  route_cmd_control_if #(.ID_W(ID_W)) bus ();

  route_cmd_control #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_HALF(BUZZ_HALF)) dut (
    .clk(clk), .rst(rst), .bus(bus), .OK2Move(OK2Move),
    .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n),
    .arrived(arrived), .ovf(ovf), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic is_ovf;
    int   q;
    logic tr;
  } ev_t;
  ev_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every arrived/ovf pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (arrived || ovf)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk(e.is_ovf ? "sb_ovf_pulse" : "sb_arrived_pulse",
            e.is_ovf ? int'(ovf) : int'(arrived), 1);
        chk("sb_single_kind", int'(arrived & ovf), 0);
        chk("sb_q_cnt", int'(q_cnt), e.q);
        chk("sb_in_transit", int'(in_transit), int'(e.tr));
      end
    end
  end

  task automatic push_ev(input logic is_ovf, input int q, input logic tr);
    ev_t e;
    e.is_ovf = is_ovf;
    e.q = q;
    e.tr = tr;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] d,
                          input int exp_q, input logic exp_tr);
    @(posedge clk); #1;
    bus.cmd = {op, d};
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    chk("clr_cmd_rdy", int'(bus.clr_cmd_rdy), 1);
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
    @(negedge clk);
    chk("cmd_q_cnt", int'(q_cnt), exp_q);
    chk("cmd_in_transit", int'(in_transit), int'(exp_tr));
  endtask

  task automatic send_id(input logic [5:0] id, input int exp_q, input logic exp_tr);
    @(posedge clk); #1;
    bus.ID = id;
    bus.ID_vld = 1'b1;
    @(negedge clk);
    chk("clr_ID_vld", int'(bus.clr_ID_vld), 1);
    @(posedge clk); #1;
    bus.ID_vld = 1'b0;
    @(negedge clk);
    chk("id_q_cnt", int'(q_cnt), exp_q);
    chk("id_in_transit", int'(in_transit), int'(exp_tr));
  endtask

  initial begin
    bus.cmd = '0;
    bus.cmd_rdy = 1'b0;
    bus.ID = '0;
    bus.ID_vld = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_transit", int'(in_transit), 0);
    chk("rst_go", int'(go), 0);
    chk("rst_buzz", int'(buzz), 0);
    chk("rst_buzz_n", int'(buzz_n), 0);
    chk("rst_q_cnt", int'(q_cnt), 0);
    chk("rst_arrived", int'(arrived), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Multi-stop route
    send_cmd(GO, 6'h0A, 1, 1'b1);
    send_cmd(ENQ, 6'h05, 2, 1'b1);
    send_cmd(ENQ, 6'h11, 3, 1'b1);
    send_id(6'h05, 3, 1'b1);
    push_ev(1'b0, 2, 1'b1);
    send_id(6'h0A, 2, 1'b1);
    push_ev(1'b0, 1, 1'b1);
    send_id(6'h05, 1, 1'b1);
    push_ev(1'b0, 0, 1'b0);
    send_id(6'h11, 0, 1'b0);

    // Overflow in IDLE, STOP, RESUME on empty
    for (int i = 1; i <= 4; i++) send_cmd(ENQ, 6'(i), i, 1'b0);
    push_ev(1'b1, 4, 1'b0);
    send_cmd(ENQ, 6'h05, 4, 1'b0);
    send_id(6'h01, 4, 1'b0);
    send_cmd(STOP, 6'h00, 0, 1'b0);
    send_cmd(RESUME, 6'h00, 0, 1'b0);

    // GO and ENQ on a full queue
    for (int i = 1; i <= 4; i++) send_cmd(ENQ, 6'(i + 8), i, 1'b0);
    push_ev(1'b1, 4, 1'b1);
    send_cmd(GO, 6'h09, 4, 1'b1);
    push_ev(1'b1, 4, 1'b1);
    send_cmd(ENQ, 6'h0F, 4, 1'b1);
    send_cmd(STOP, 6'h00, 0, 1'b0);

    // RESUME with entries pending
    send_cmd(ENQ, 6'h2A, 1, 1'b0);
    send_cmd(RESUME, 6'h00, 1, 1'b1);
    send_cmd(STOP, 6'h00, 0, 1'b0);

    // Command/ID collision
    send_cmd(GO, 6'h20, 1, 1'b1);
    @(posedge clk); #1;
    bus.cmd = {ENQ, 6'h07};
    bus.cmd_rdy = 1'b1;
    bus.ID = 6'h20;
    bus.ID_vld = 1'b1;
    @(negedge clk);
    chk("coll_clr_cmd_rdy", int'(bus.clr_cmd_rdy), 1);
    chk("coll_clr_ID_vld", int'(bus.clr_ID_vld), 0);
    push_ev(1'b0, 1, 1'b1);
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
    @(negedge clk);
    chk("coll_clr_ID_vld_next", int'(bus.clr_ID_vld), 1);
    chk("coll_q_before_pop", int'(q_cnt), 2);
    @(posedge clk); #1;
    bus.ID_vld = 1'b0;
    @(negedge clk);
    chk("coll_q_after_pop", int'(q_cnt), 1);
    chk("coll_in_transit", int'(in_transit), 1);
    push_ev(1'b0, 0, 1'b0);
    send_id(6'h07, 0, 1'b0);

    // Buzzer / go
    send_cmd(GO, 6'h15, 1, 1'b1);
    chk("go_clear_path", int'(go), 1);
    chk("buzz_idle", int'(buzz), 0);
    @(posedge clk); #1;
    OK2Move = 1'b0;
    @(negedge clk);
    chk("go_blocked", int'(go), 0);
    for (int i = 0; i < 4 * BUZZ_HALF; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("buzz_wave", int'(buzz), ((i / BUZZ_HALF) % 2 == 0) ? 1 : 0);
      chk("buzz_n_wave", int'(buzz_n), ((i / BUZZ_HALF) % 2 == 0) ? 0 : 1);
    end
    @(posedge clk); #1;
    OK2Move = 1'b1;
    @(negedge clk);
    chk("go_resumed", int'(go), 1);
    @(posedge clk);
    @(negedge clk);
    chk("buzz_off", int'(buzz), 0);
    chk("buzz_n_off", int'(buzz_n), 0);
    send_cmd(STOP, 6'h00, 0, 1'b0);
    chk("go_after_stop", int'(go), 0);

    // Reset mid-route
    send_cmd(GO, 6'h0C, 1, 1'b1);
    send_cmd(ENQ, 6'h0D, 2, 1'b1);
    send_cmd(ENQ, 6'h0E, 3, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_q_cnt", int'(q_cnt), 0);
    chk("midrst_in_transit", int'(in_transit), 0);
    send_cmd(GO, 6'h01, 1, 1'b1);
    send_id(6'h0C, 1, 1'b1);
    push_ev(1'b0, 0, 1'b0);
    send_id(6'h01, 0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/route_cmd_control.md
# route_cmd_control

Parametrised command-and-control block for the follower: generalises single-destination go/stop control to a queued multi-stop route. Accepts UART-decoded commands, holds up to DEPTH destination IDs in a FIFO, and compares barcode IDs against the head entry. Each match pops the head; the follower idles only when the route empties or a STOP arrives. Sits between the UART command receiver, the barcode reader and the motion/piezo logic.

## Interface
- ID_W, 6: destination/station ID width; command width is ID_W+2.
- DEPTH, 4: route queue depth, ≥2.
- BUZZ_HALF, 4: buzzer half-period in clk cycles, ≥1.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd  input  ID_W+2  opcode cmd[ID_W+1:ID_W], destination cmd[ID_W-1:0].
- cmd_rdy  input  1  cmd valid, held until cleared.
- clr_cmd_rdy  output  1  consume pulse for cmd_rdy.
- ID  input  ID_W  station ID from barcode reader.
- ID_vld  input  1  ID valid, held until cleared.
- clr_ID_vld  output  1  consume pulse for ID_vld.
- OK2Move  input  1  path clear from proximity sensing.
- in_transit  output  1  route active.
- go  output  1  motion enable.
- buzz, buzz_n  output  1 each  differential piezo drive.
- arrived  output  1  one-cycle pulse on head match.
- ovf  output  1  one-cycle pulse, push dropped on full queue.
- q_cnt  output  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- States: IDLE (in_transit=0), TRANSIT (in_transit=1). in_transit is the registered state bit.
- Opcodes: 00 STOP, 01 GO, 10 ENQ, 11 RESUME.
- STOP: flush queue (q_cnt→0), go to IDLE.
- GO: push destination, go to TRANSIT. Full queue: drop push, pulse ovf, still enter TRANSIT.
- ENQ: push destination, state unchanged. Full queue: drop, pulse ovf.
- RESUME: enter TRANSIT if q_cnt≠0, else ignore.
- Every cmd_rdy is consumed: clr_cmd_rdy=cmd_rdy, combinational, in all states.
- ID_vld with no cmd_rdy pending: clr_ID_vld=1 combinational, in any state.
  - In TRANSIT with ID==head: pop, pulse arrived. If q_cnt was 1, go to IDLE, else stay in TRANSIT for the next stop.
  - Mismatch, or in IDLE: no effect beyond clearing.
- Priority: cmd_rdy and ID_vld high in the same cycle → command executes. clr_ID_vld=0 that cycle; ID is evaluated on the next cycle. Push and pop never coincide.
- Queue: circular buffer, wr/rd pointers wrap modulo DEPTH. Entries are pushed in arrival order; head is the oldest entry.
- go = in_transit & OK2Move, combinational.
- Buzzer is active when in_transit & ~OK2Move. Active: buzz toggles every BUZZ_HALF cycles, buzz_n = ~buzz. Inactive: counter held at 0, buzz=0, buzz_n=0.

## Timing
- Reset values (edge with rst=1): state IDLE, in_transit=0, q_cnt=0, pointers=0, buzz=0, buzz_n=0, arrived=0, ovf=0. go follows in_transit, so go=0. rst mid-route discards the queue.
- Command latency: in_transit/q_cnt update on the edge that samples cmd_rdy=1. arrived/ovf are registered, high for exactly the cycle after that edge.
- Head match at q_cnt=1: in_transit falls on the same edge that arrived is registered.
- Buzzer: first edge with active condition loads buzz=1 and counter=0. buzz=1 for BUZZ_HALF cycles, then 0 for BUZZ_HALF cycles, repeating. Condition dropping forces buzz/buzz_n to 0 on the next edge.
- ENQ on full queue while in TRANSIT: queue unchanged, ovf pulses, state held.

## Test plan
- Reset: rst=1 two cycles, then all outputs 0 (buzz_n=0, q_cnt=0). cmd_rdy=1, cmd={01,6'h0A} → clr_cmd_rdy same cycle, next cycle in_transit=1, q_cnt=1.
- Multi-stop route: GO 0A, ENQ 05, ENQ 11; ID_vld with ID=05 → no pop. ID=0A → arrived, q_cnt=2, in_transit=1. ID=05, then ID=11 → q_cnt=0, in_transit=0.
- Overflow: 5 ENQs into DEPTH=4 → q_cnt=4, ovf pulses once. STOP → q_cnt=0, in_transit=0. RESUME on empty queue → stays IDLE.
- Collision: cmd_rdy (ENQ 07) and ID_vld (ID=head) in the same cycle → clr_cmd_rdy=1, clr_ID_vld=0. Next cycle clr_ID_vld=1 and pop.
- Buzzer/go: TRANSIT with OK2Move=0 → go=0, buzz 4 high/4 low, buzz_n inverted. OK2Move=1 → go=1, buzz=buzz_n=0 next cycle.
- Reset mid-route: q_cnt=3 in TRANSIT, rst pulse → q_cnt=0, in_transit=0. Later GO 01 → head=01.
